// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and opcode helper for the ALU sequencer.
package alu_seq_ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_defined(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_OR) || (op == ALU_AND);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// Combinational ALU: ADD/SUB wrap modulo 2^N; undefined opcodes give r=0 and err=1.
module alu_seq_ctrl_alu
    import alu_seq_ctrl_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [2:0]   opcode_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] r_o,
    output logic         err_o
);

    always_comb begin
        r_o   = '0;
        err_o = !op_defined(opcode_i);
        case (opcode_i)
            ALU_ADD: r_o = a_i + b_i;
            ALU_SUB: r_o = a_i - b_i;
            ALU_OR:  r_o = a_i | b_i;
            ALU_AND: r_o = a_i & b_i;
            default: r_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer: register file + IDLE/EXEC/RESP FSM driving one ALU,
// returning results on a valid/ready channel and writing them back on handshake.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          wr_en,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_rd,
    output logic [N-1:0]  out_data,
    output logic          out_err
);

    state_e        state_q;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q, rs1_q, rs2_q;
    logic [N-1:0]  regs_q [NREG];
    logic [AW-1:0] out_rd_q;
    logic [N-1:0]  out_data_q;
    logic          out_err_q;

    logic [N-1:0]  alu_a, alu_b, alu_r;
    logic          alu_err;

    // Register 0 is never written, so reading it directly always yields 0.
    assign alu_a = regs_q[rs1_q];
    assign alu_b = regs_q[rs2_q];

    alu_seq_ctrl_alu #(.N(N)) u_alu (
        .opcode_i (op_q),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .r_o      (alu_r),
        .err_o    (alu_err)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_IDLE) && !in_valid;
    assign out_valid = (state_q == ST_RESP);
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            out_rd_q   <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // An instruction takes priority; a concurrent load is refused.
                    if (in_valid) begin
                        op_q    <= in_op;
                        rd_q    <= in_rd;
                        rs1_q   <= in_rs1;
                        rs2_q   <= in_rs2;
                        state_q <= ST_EXEC;
                    end else if (wr_en && (wr_addr != '0)) begin
                        regs_q[wr_addr] <= wr_data;
                    end
                end
                ST_EXEC: begin
                    out_data_q <= alu_r;
                    out_rd_q   <= rd_q;
                    out_err_q  <= alu_err;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        if (!out_err_q && (out_rd_q != '0)) regs_q[out_rd_q] <= out_data_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus pushes model results, a monitor pops on handshake.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int N    = 16;
    localparam int NREG = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic          wr_en, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          out_valid, out_ready;
    logic [AW-1:0] out_rd;
    logic [N-1:0]  out_data;
    logic          out_err;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.N(N), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_err(out_err)
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [N-1:0]  data;
        logic          err;
    } resp_t;

    resp_t        exp_q[$];
    logic [N-1:0] model [NREG];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           rdy_mode = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b required %0b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout required handshake", name);
    endtask

    // Reference model: operands from the model register array, spec arithmetic.
    function automatic resp_t ref_exec(input logic [2:0] op, input logic [AW-1:0] rd,
                                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        resp_t        r;
        logic [N-1:0] a, b;
        a = (rs1 == 0) ? '0 : model[rs1];
        b = (rs2 == 0) ? '0 : model[rs2];
        r.rd  = rd;
        r.err = 1'b0;
        case (op)
            ALU_ADD: r.data = a + b;
            ALU_SUB: r.data = a - b;
            ALU_OR:  r.data = a | b;
            ALU_AND: r.data = a & b;
            default: begin r.data = '0; r.err = 1'b1; end
        endcase
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) model[i] = '0;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on each handshake, check stability while stalled.
    initial begin
        resp_t e, cur, prev;
        logic  prev_hold;
        prev_hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else if (out_valid) begin
                cur = {out_rd, out_data, out_err};
                check_bit("busy_in_ready", in_ready, 1'b0);
                check_bit("busy_wr_ready", wr_ready, 1'b0);
                if (prev_hold) begin
                    n_chk++;
                    if (cur !== prev) begin
                        n_fail++;
                        $display("FAIL stall_stable: got %0h required %0h", cur, prev);
                    end
                end
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got out_valid=1 required no pending result");
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check_val("resp_rd", N'(out_rd), N'(e.rd));
                    check_val("resp_data", out_data, e.data);
                    check_bit("resp_err", out_err, e.err);
                end
                prev_hold = !out_ready;
                prev = cur;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
        bit ok;
        ok = 1'b0;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (!ok) timeout("load_wait");
        else if (a != 0) model[a] = d;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        resp_t r;
        bit    ok;
        ok = 1'b0;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            r = ref_exec(op, rd, rs1, rs2);
            exp_q.push_back(r);
            if (!r.err && rd != 0) model[rd] = r.data;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) timeout("issue_wait");
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        if (!ok) timeout("drain");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_data", out_data, '0);
        check_val("rst_out_rd", N'(out_rd), '0);
        check_bit("rst_out_err", out_err, 1'b0);
        exp_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] rop;
        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_val("reset_out_data", out_data, '0);
        check_val("reset_out_rd", N'(out_rd), '0);
        check_bit("reset_out_err", out_err, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic ADD with latency check, then read back the written register
        load(3'd1, 16'd40);
        load(3'd2, 16'd2);
        issue(ALU_ADD, 3'd3, 3'd1, 3'd2);
        check_bit("latency_exec", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_bit("latency_resp", out_valid, 1'b1);
        drain();
        issue(ALU_ADD, 3'd6, 3'd3, 3'd0);

        // SUB both directions, ADD wrap
        issue(ALU_SUB, 3'd4, 3'd1, 3'd2);
        issue(ALU_SUB, 3'd5, 3'd2, 3'd1);
        load(3'd7, 16'hFFFF);
        load(3'd6, 16'd1);
        issue(ALU_ADD, 3'd3, 3'd7, 3'd6);
        issue(ALU_ADD, 3'd6, 3'd5, 3'd0);

        // OR / AND, undefined opcode leaves rd untouched
        load(3'd4, 16'd31);
        issue(ALU_OR,  3'd5, 3'd1, 3'd4);
        issue(ALU_AND, 3'd5, 3'd1, 3'd4);
        issue(3'b111,  3'd5, 3'd1, 3'd4);
        issue(ALU_ADD, 3'd6, 3'd5, 3'd0);
        drain();

        // Stall the result channel for several cycles
        rdy_mode = 2;
        @(posedge clk);
        #1;
        issue(ALU_OR, 3'd6, 3'd1, 3'd2);
        repeat (6) @(posedge clk);
        #1;
        check_bit("stall_valid", out_valid, 1'b1);
        rdy_mode = 0;
        drain();

        // Instruction and load in the same IDLE cycle: load refused
        in_valid = 1'b1; in_op = ALU_ADD; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'd999;
        @(negedge clk);
        check_bit("collide_in_ready", in_ready, 1'b1);
        check_bit("collide_wr_ready", wr_ready, 1'b0);
        exp_q.push_back(ref_exec(ALU_ADD, 3'd3, 3'd1, 3'd0));
        model[3] = model[1];
        @(posedge clk);
        #1;
        in_valid = 1'b0; wr_en = 1'b0;
        issue(ALU_ADD, 3'd6, 3'd1, 3'd0);

        // Register 0 stays zero under writeback and load
        issue(ALU_ADD, 3'd0, 3'd1, 3'd2);
        load(3'd0, 16'd1234);
        issue(ALU_ADD, 3'd6, 3'd0, 3'd0);
        issue(ALU_OR,  3'd6, 3'd0, 3'd1);
        drain();

        // Reset while in EXEC
        issue(ALU_ADD, 3'd3, 3'd1, 3'd2);
        pulse_reset();
        issue(ALU_ADD, 3'd3, 3'd1, 3'd2);
        drain();

        // Reset while in RESP
        load(3'd1, 16'd5);
        load(3'd2, 16'd7);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        issue(ALU_ADD, 3'd3, 3'd1, 3'd2);
        @(posedge clk);
        #1;
        check_bit("pre_rst_resp_valid", out_valid, 1'b1);
        pulse_reset();
        rdy_mode = 0;
        issue(ALU_ADD, 3'd4, 3'd1, 3'd2);
        load(3'd1, 16'd5);
        load(3'd2, 16'd7);
        issue(ALU_ADD, 3'd4, 3'd1, 3'd2);
        drain();

        // Randomized mix with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(AW'($urandom_range(0, NREG - 1)), N'($urandom));
            end else begin
                rop = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                issue(rop, AW'($urandom_range(0, NREG - 1)),
                      AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)));
            end
        end
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion required completion");
        $fatal(1);
    end

endmodule
